// File: rtl/subleq_core_pkg.sv
// Shared word size, state encodings and the leq helper for the SUBLEQ core.
package subleq_core_pkg;

  localparam int WORD_SIZE   = 8;
  localparam int STATE_WIDTH = 3;

  // Encodings are exported so a bench can probe the FSM directly.
  localparam logic [STATE_WIDTH-1:0] STATE_FETCH_A = 3'd0;
  localparam logic [STATE_WIDTH-1:0] STATE_FETCH_B = 3'd1;
  localparam logic [STATE_WIDTH-1:0] STATE_FETCH_C = 3'd2;
  localparam logic [STATE_WIDTH-1:0] STATE_LOAD_A  = 3'd3;
  localparam logic [STATE_WIDTH-1:0] STATE_LOAD_B  = 3'd4;
  localparam logic [STATE_WIDTH-1:0] STATE_WRITE_B = 3'd5;
  localparam logic [STATE_WIDTH-1:0] STATE_HALT    = 3'd6;

  // Two's-complement "less than or equal to zero" test on a word.
  function automatic logic is_leq(input logic [WORD_SIZE-1:0] v);
    return v[WORD_SIZE-1] | (v == '0);
  endfunction

endpackage

// File: rtl/subleq_core_if.sv
// Word-addressed memory port between the SUBLEQ core (master) and memory (slave).
interface subleq_core_if
  import subleq_core_pkg::*;
#(
  parameter int W = WORD_SIZE
);
  logic         load;
  logic         store;
  logic [W-1:0] addr;
  logic [W-1:0] mem_in;
  logic [W-1:0] mem_out;

  modport master (output load, output store, output addr, output mem_in, input mem_out);
  modport slave  (input load, input store, input addr, input mem_in, output mem_out);
endinterface

// File: rtl/subleq_alu.sv
// Combinational SUBLEQ datapath: result = vb - va (wrapping) and the leq flag.
module subleq_alu
  import subleq_core_pkg::*;
(
  input  logic [WORD_SIZE-1:0] va_i,
  input  logic [WORD_SIZE-1:0] vb_i,
  output logic [WORD_SIZE-1:0] result_o,
  output logic                 leq_o
);

  // Subtract modulo 2^WORD_SIZE and flag non-positive results.
  always_comb begin
    result_o = vb_i - va_i;
    leq_o    = is_leq(result_o);
  end

endmodule

// File: rtl/subleq_core.sv
// SUBLEQ instruction sequencer: one memory access per cycle, 6 cycles per instruction.
module subleq_core
  import subleq_core_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] HALT_ADDR = WORD_SIZE'((1 << WORD_SIZE) - 1)
)(
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 run,
  subleq_core_if.master        mem,
  output logic                 halted,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 instr_done
);

  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic [WORD_SIZE-1:0]   pc_q, pc_d;
  logic [WORD_SIZE-1:0]   a_q, a_d;
  logic [WORD_SIZE-1:0]   b_q, b_d;
  logic [WORD_SIZE-1:0]   c_q, c_d;
  logic [WORD_SIZE-1:0]   va_q, va_d;
  logic [WORD_SIZE-1:0]   vb_q, vb_d;

  logic [WORD_SIZE-1:0]   result;
  logic                   leq;
  logic [WORD_SIZE-1:0]   next_pc;

  subleq_alu u_alu (
    .va_i     (va_q),
    .vb_i     (vb_q),
    .result_o (result),
    .leq_o    (leq)
  );

  // Branch target; pc+3 wraps naturally at the word width.
  assign next_pc = leq ? c_q : (pc_q + WORD_SIZE'(3));
  assign pc      = pc_q;

  // Port decode from state; store/instr_done are gated by run so a stall defers the write.
  always_comb begin
    mem.load   = 1'b0;
    mem.store  = 1'b0;
    mem.addr   = '0;
    mem.mem_in = '0;
    halted     = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      STATE_FETCH_A: begin mem.load = 1'b1; mem.addr = pc_q; end
      STATE_FETCH_B: begin mem.load = 1'b1; mem.addr = pc_q + WORD_SIZE'(1); end
      STATE_FETCH_C: begin mem.load = 1'b1; mem.addr = pc_q + WORD_SIZE'(2); end
      STATE_LOAD_A:  begin mem.load = 1'b1; mem.addr = a_q; end
      STATE_LOAD_B:  begin mem.load = 1'b1; mem.addr = b_q; end
      STATE_WRITE_B: begin
        mem.store  = run;
        mem.addr   = b_q;
        mem.mem_in = result;
        instr_done = run;
      end
      STATE_HALT:    halted = 1'b1;
      default:       ;
    endcase
  end

  // Next-state and operand capture; everything holds while run is low.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    va_d    = va_q;
    vb_d    = vb_q;
    if (run) begin
      case (state_q)
        STATE_FETCH_A: begin a_d  = mem.mem_out; state_d = STATE_FETCH_B; end
        STATE_FETCH_B: begin b_d  = mem.mem_out; state_d = STATE_FETCH_C; end
        STATE_FETCH_C: begin c_d  = mem.mem_out; state_d = STATE_LOAD_A;  end
        STATE_LOAD_A:  begin va_d = mem.mem_out; state_d = STATE_LOAD_B;  end
        STATE_LOAD_B:  begin vb_d = mem.mem_out; state_d = STATE_WRITE_B; end
        STATE_WRITE_B: begin
          pc_d    = next_pc;
          state_d = (next_pc == HALT_ADDR) ? STATE_HALT : STATE_FETCH_A;
        end
        STATE_HALT:    state_d = STATE_HALT;
        default:       state_d = STATE_FETCH_A;
      endcase
    end
  end

  // State and operand registers, cleared asynchronously.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= STATE_FETCH_A;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      va_q    <= '0;
      vb_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
    end
  end

endmodule

// File: doc/subleq_core.md
Name: subleq_core

Overview:
- Instruction sequencer for the SUBLEQ machine. It is the initiator side of the memory port.
- Drives load/store/addr/mem_in into the word-addressed memory and consumes its combinational mem_out.
- Executes `mem[B] = mem[B] - mem[A]; if result <= 0 then pc = C else pc = pc + 3`, one memory access per cycle.
- Sits at top level beside the memory; its memory port connects to the memory one-to-one.

Parameters:
- HALT_ADDR, default (1 << `WORD_SIZE) - 1: when the next-pc value equals this address, the core halts. Must be nonzero.

Ports:
- clk  input  1  system clock, rising edge.
- areset  input  1  asynchronous reset, active-high.
- run  input  1  advance enable; 0 freezes the FSM.
- load  output  1  memory read strobe.
- store  output  1  memory write strobe; the memory samples it on posedge clk.
- addr  output  `WORD_SIZE  memory address.
- mem_in  output  `WORD_SIZE  write data to memory.
- mem_out  input  `WORD_SIZE  read data from memory; combinational and valid in the same cycle as load/addr.
- halted  output  1  core stopped at HALT_ADDR.
- pc  output  `WORD_SIZE  current program counter.
- instr_done  output  1  one-cycle pulse on the cycle whose edge commits an instruction.

Behaviour:
- States, one cycle each while run=1: FETCH_A, FETCH_B, FETCH_C, LOAD_A, LOAD_B, WRITE_B, HALT.
- Steady state: 6 cycles per instruction.
- FETCH_A: load=1, addr=pc; a <= mem_out.
- FETCH_B: load=1, addr=pc+1; b <= mem_out.
- FETCH_C: load=1, addr=pc+2; c <= mem_out.
- LOAD_A: load=1, addr=a; va <= mem_out.
- LOAD_B: load=1, addr=b; vb <= mem_out.
- WRITE_B:
  - store=1, load=0, addr=b, mem_in = vb - va.
  - Subtraction is modulo 2^`WORD_SIZE.
  - leq = (result MSB == 1) or (result == 0), i.e. a two's-complement compare.
  - next_pc = leq ? c : pc+3.
  - At the edge: pc <= next_pc; go to HALT if next_pc == HALT_ADDR, else FETCH_A.
- instr_done = 1 in WRITE_B when run=1.
- HALT: load=0, store=0, addr=0, halted=1. The only exit is areset.
- Address arithmetic (pc+1, pc+2, pc+3) wraps modulo 2^`WORD_SIZE, with no special case.
- Outputs are decoded combinationally from state and registers. store is asserted only in WRITE_B with run=1.
- Outputs not listed for a state are 0: mem_in=0 outside WRITE_B, load=0 in WRITE_B.
- run=0:
  - State and all registers hold.
  - store and instr_done are forced 0. load/addr keep their state-decoded values, which is harmless.
  - A write pending in WRITE_B is deferred until run returns to 1.
- areset asserted, asynchronous:
  - state=FETCH_A; pc, a, b, c, va, vb = 0.
  - halted=0, store=0, instr_done=0.
  - While held: load=1, addr=0, which is legal since the memory reloads on reset.
  - Takes effect mid-instruction with no partial write. A WRITE_B cut by reset before the edge does not write.
- Self-modifying code is supported without hazard: every operand is re-read from memory after the previous WRITE_B edge.
- The initial pc=0 is never compared against HALT_ADDR. The comparison applies only at WRITE_B.

Decomposition:
- Shared `defines.vh`: existing `WORD_SIZE`; add `STATE_WIDTH` (3) and `STATE_FETCH_A` .. `STATE_HALT` encodings so the bench can probe state.
- One natural sub-module: `subleq_alu`.
  - Inputs: va, vb.
  - Outputs: result = vb - va, and leq.
  - Purely combinational, unit-testable in isolation.
- The FSM, registers and port decode stay in subleq_core.

Test Plan:
All cases use `WORD_SIZE=8, HALT_ADDR=0xFF and the real memory model, with run=1 unless stated.
- Not taken: mem[0..2]=0x0A,0x0B,0x20, mem[0x0A]=5, mem[0x0B]=7, run=1 -> after 6 edges mem[0x0B]=2, pc=3, instr_done high exactly in cycle 6.
- Taken negative: mem[0x0A]=7, mem[0x0B]=5 -> mem[0x0B]=0xFE, pc=0x20.
- Zero result: mem[0x0A]=mem[0x0B]=9 -> mem[0x0B]=0, pc=0x20.
- Halt: C=0xFF and branch taken -> halted=1 from cycle 7 on; load=store=0 for 20 further cycles; pc=0xFF.
- Not-taken halt: at pc=0xFC with a not-taken branch, next_pc=0xFF -> halted=1.
- Reset mid-instruction: assert areset asynchronously during LOAD_B (between edges) -> state=FETCH_A and pc=0 immediately; memory unchanged; after release the instruction re-executes correctly.
- run stall and wrap:
  - Drop run during WRITE_B for 3 cycles -> store=0, memory unchanged; the write lands on the first edge with run=1.
  - Separately, pc=0xFD not taken -> fetch addresses 0xFD, 0xFE, 0xFF, then pc=0x00.
